// File: rtl/fft_frame_sequencer_if.sv
// Streaming bundle between the frame sequencer, the ADC front end and the FFT core.
// master = sequencer side (consumes ADC/FFT-source, drives FFT sink); slave = environment side.
interface fft_frame_sequencer_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] adc_data;
  logic              adc_valid;
  logic              sink_ready;
  logic              sink_valid;
  logic              sink_sop;
  logic              sink_eop;
  logic [DATA_W-1:0] sink_data;
  logic              source_sop;
  logic              source_eop;

  modport master (
    input  adc_data, adc_valid, sink_ready, source_sop, source_eop,
    output sink_valid, sink_sop, sink_eop, sink_data
  );

  modport slave (
    output adc_data, adc_valid, sink_ready, source_sop, source_eop,
    input  sink_valid, sink_sop, sink_eop, sink_data
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frames ADC samples into FFT_LEN blocks, keeps one frame in flight, then pulses result_valid.
// Optional macro DECIM_EN adds the decim[7:0] input: only every (decim+1)-th adc_valid is offered.
module fft_frame_sequencer #(
  parameter int FFT_LEN = 1024,
  parameter int DATA_W  = 12,
  parameter int SETTLE  = 24,
  parameter int TIMEOUT = 65535
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        continuous,
  input  logic                        stop,
`ifdef DECIM_EN
  input  logic [7:0]                  decim,
`endif
  fft_frame_sequencer_if.master       stream,
  output logic                        result_valid,
  output logic                        busy,
  output logic                        overrun,
  output logic                        timeout_err,
  output logic [15:0]                 frame_count
);

  localparam int IDX_W   = $clog2(FFT_LEN);
  localparam int CNT_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_WAIT_FFT,
    S_SETTLE_WAIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                stop_pending_q, stop_pending_d;
  logic                sink_valid_q, sink_valid_d;
  logic                sink_sop_q, sink_sop_d;
  logic                sink_eop_q, sink_eop_d;
  logic [DATA_W-1:0]   sink_data_q, sink_data_d;
  logic                result_valid_q, result_valid_d;
  logic                overrun_q, overrun_d;
  logic                timeout_err_q, timeout_err_d;
  logic [15:0]         frame_count_q, frame_count_d;

  logic sel, accept, drop, last, timeout_hit, settle_done, stop_eff;

`ifdef DECIM_EN
  logic [7:0] dcnt_q, dcnt_d;
  assign sel = (dcnt_q == 8'd0);
`else
  assign sel = 1'b1;
`endif

  assign accept      = (state_q == S_FEED) && stream.adc_valid && stream.sink_ready && sel;
  assign drop        = (state_q == S_FEED) && stream.adc_valid && !stream.sink_ready && sel;
  assign last        = accept && (idx_q == IDX_W'(FFT_LEN - 1));
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign settle_done = (cnt_q == CNT_W'(SETTLE - 1));
  // A stop arriving in the DONE cycle itself must still prevent re-arming.
  assign stop_eff    = stop_pending_q | stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:        if (start) state_d = S_FEED;
      S_FEED:        if (last) state_d = S_WAIT_FFT;
      S_WAIT_FFT: begin
        if (stream.source_eop)                           state_d = S_SETTLE_WAIT;
        else if (!stream.source_sop && timeout_hit)      state_d = S_IDLE;
      end
      S_SETTLE_WAIT: if (settle_done) state_d = S_DONE;
      S_DONE:        state_d = (continuous && !stop_eff) ? S_FEED : S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    stop_pending_d = stop_pending_q;
    sink_valid_d   = accept;
    sink_sop_d     = accept && (idx_q == '0);
    sink_eop_d     = last;
    sink_data_d    = accept ? stream.adc_data : sink_data_q;
    result_valid_d = 1'b0;
    overrun_d      = overrun_q;
    timeout_err_d  = timeout_err_q;
    frame_count_d  = frame_count_q;

    if ((state_q != S_IDLE) && stop) stop_pending_d = 1'b1;
    if (state_d == S_IDLE)           stop_pending_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          overrun_d     = 1'b0;
          timeout_err_d = 1'b0;
          idx_d         = '0;
        end
      end
      S_FEED: begin
        if (accept) idx_d = last ? '0 : idx_q + IDX_W'(1);
        if (drop)   overrun_d = 1'b1;
        if (last)   cnt_d = '0;
      end
      S_WAIT_FFT: begin
        if (stream.source_eop || stream.source_sop) begin
          cnt_d = '0;
        end else if (timeout_hit) begin
          timeout_err_d = 1'b1;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETTLE_WAIT: begin
        if (settle_done) begin
          result_valid_d = 1'b1;
          frame_count_d  = frame_count_q + 16'd1;
          cnt_d          = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  idx_d = '0;
      default: idx_d = '0;
    endcase
  end

`ifdef DECIM_EN
  always_comb begin
    dcnt_d = dcnt_q;
    if ((state_d == S_FEED) && (state_q != S_FEED)) begin
      dcnt_d = 8'd0;
    end else if ((state_q == S_FEED) && stream.adc_valid) begin
      dcnt_d = (dcnt_q >= decim) ? 8'd0 : dcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dcnt_q <= 8'd0;
    else        dcnt_q <= dcnt_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q          <= '0;
      cnt_q          <= '0;
      stop_pending_q <= 1'b0;
      sink_valid_q   <= 1'b0;
      sink_sop_q     <= 1'b0;
      sink_eop_q     <= 1'b0;
      sink_data_q    <= '0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
      frame_count_q  <= 16'd0;
    end else begin
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      stop_pending_q <= stop_pending_d;
      sink_valid_q   <= sink_valid_d;
      sink_sop_q     <= sink_sop_d;
      sink_eop_q     <= sink_eop_d;
      sink_data_q    <= sink_data_d;
      result_valid_q <= result_valid_d;
      overrun_q      <= overrun_d;
      timeout_err_q  <= timeout_err_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign stream.sink_valid = sink_valid_q;
  assign stream.sink_sop   = sink_sop_q;
  assign stream.sink_eop   = sink_eop_q;
  assign stream.sink_data  = sink_data_q;
  assign result_valid      = result_valid_q;
  assign busy              = (state_q != S_IDLE);
  assign overrun           = overrun_q;
  assign timeout_err       = timeout_err_q;
  assign frame_count       = frame_count_q;

endmodule
